pcie_tx_injector: RTL and testbench

Transmit-side traffic source for the PCIE switch. Accepts 8-bit payloads with a 2-bit destination from four per-class producers, arbitrates round-robin among classes and emits 12-bit words `{class[1:0], dest[1:0], data[7:0]}` as push/data into the switch input FIFO. Push is gated by a credit counter sized to the input-FIFO depth and replenished by the switch's input-FIFO pop pulse, so the input FIFO never overflows.

---
 rtl/pcie_tx_injector_if.sv | 25 ++
 rtl/pcie_tx_injector.sv | 153 +++++++++++++++
 tb/tb_pcie_tx_injector.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_tx_injector_if.sv
// Producer/switch-side bundle for pcie_tx_injector: per-class source handshake,
// push/data toward the switch input FIFO and the credit-return pulse.
interface pcie_tx_injector_if #(
    parameter int TAMANO_DATOS = 12
);
    logic [3:0]              src_valid;
    logic [7:0]              src_dest;
    logic [31:0]             src_data;
    logic [3:0]              src_ready;
    logic                    credit_ret;
    logic                    push;
    logic [TAMANO_DATOS-1:0] data_out;

    // Environment side: producers and the switch input FIFO.
    modport master (
        output src_valid, src_dest, src_data, credit_ret,
        input  src_ready, push, data_out
    );

    // Injector side.
    modport slave (
        input  src_valid, src_dest, src_data, credit_ret,
        output src_ready, push, data_out
    );
endinterface

// File: rtl/pcie_tx_injector.sv
// Round-robin, credit-gated transmit injector for the PCIE switch input FIFO.
// Optional per-class handshake counters are enabled with `define PCIE_TX_STATS_EN.
module pcie_tx_injector #(
    parameter int TAMANO_DATOS = 12,
    parameter int CREDITOS     = 8,
    parameter int CREDIT_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    pcie_tx_injector_if.slave   bus,
    output logic [CREDIT_W-1:0] credits,
    output logic                idle,
    output logic                error
`ifdef PCIE_TX_STATS_EN
    ,
    output logic [31:0]         cnt_class
`endif
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACTIVE,
        ST_STALL
    } state_t;

    localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(CREDITOS);
    localparam logic [CREDIT_W-1:0] CRED_ONE = CREDIT_W'(1);

    state_t                  r_state;
    logic [CREDIT_W-1:0]     r_credits;
    logic [1:0]              r_rr_ptr;
    logic                    r_push;
    logic [TAMANO_DATOS-1:0] r_data_out;
    logic                    r_error;

    logic [3:0]              w_grant;
    logic [1:0]              w_grant_idx;
    logic                    w_hs;
    logic [11:0]             w_word;
    logic [CREDIT_W-1:0]     w_credits_nxt;
    logic                    w_overflow;

    // Scan classes upward from rr_ptr; the first valid one wins while credits remain.
    always_comb begin
        logic [1:0] v_idx;
        logic       v_found;
        // NOTE: every combinational output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        w_grant     = '0;
        w_grant_idx = '0;
        v_found     = 1'b0;
        v_idx       = '0;
        if (r_state == ST_ACTIVE && r_credits != '0) begin
            for (int i = 0; i < 4; i++) begin
                v_idx = r_rr_ptr + 2'(i);
                if (!v_found && bus.src_valid[v_idx]) begin
                    v_found          = 1'b1;
                    w_grant[v_idx]   = 1'b1;
                    w_grant_idx      = v_idx;
                end
            end
        end
        w_hs = v_found;
    end

    assign w_word = {w_grant_idx,
                     bus.src_dest[{w_grant_idx, 1'b0} +: 2],
                     bus.src_data[{w_grant_idx, 3'b000} +: 8]};

    // Simultaneous handshake and return cancel; a return into a full counter is an error.
    always_comb begin
        w_credits_nxt = r_credits;
        w_overflow    = 1'b0;
        if (w_hs && !bus.credit_ret) begin
            w_credits_nxt = r_credits - CRED_ONE;
        end else if (!w_hs && bus.credit_ret) begin
            if (r_credits == CRED_MAX) begin
                w_overflow = 1'b1;
            end else begin
                w_credits_nxt = r_credits + CRED_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_INIT;
            r_credits  <= '0;
            r_rr_ptr   <= '0;
            r_push     <= 1'b0;
            r_data_out <= '0;
            r_error    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples
            // the pre-edge values regardless of statement order.
            r_push <= w_hs;
            if (w_hs) begin
                r_data_out <= TAMANO_DATOS'(w_word);
                r_rr_ptr   <= w_grant_idx + 2'd1;
            end

            if (r_state == ST_INIT) begin
                r_credits <= CRED_MAX;
            end else begin
                r_credits <= w_credits_nxt;
                if (w_overflow) r_error <= 1'b1;
            end

            case (r_state)
                ST_INIT: r_state <= ST_IDLE;
                ST_IDLE: begin
                    if (init)                r_state <= ST_INIT;
                    else if (|bus.src_valid) r_state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (~|bus.src_valid)          r_state <= ST_IDLE;
                    else if (w_credits_nxt == '0) r_state <= ST_STALL;
                end
                ST_STALL: begin
                    if (bus.credit_ret) r_state <= ST_ACTIVE;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign bus.src_ready = w_grant;
    assign bus.push      = r_push;
    assign bus.data_out  = r_data_out;
    assign credits       = r_credits;
    assign idle          = (r_state == ST_IDLE);
    assign error         = r_error;

`ifdef PCIE_TX_STATS_EN
    logic [31:0] r_cnt_class;

    // Per-class handshake counts, one byte each, wrapping at 256.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_class <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt_class <= '0;
        end else if (w_hs) begin
            r_cnt_class[{w_grant_idx, 3'b000} +: 8] <= r_cnt_class[{w_grant_idx, 3'b000} +: 8] + 8'd1;
        end
    end

    assign cnt_class = r_cnt_class;
`endif

endmodule

// File: tb/tb_pcie_tx_injector.sv
// Scoreboard bench for pcie_tx_injector: a rule-level model predicts grants and
// words; a posedge monitor pops expected words and compares every DUT output.
module tb_pcie_tx_injector;

    localparam int CREDITOS = 8;
    localparam int M_INIT   = 0;
    localparam int M_IDLE   = 1;
    localparam int M_ACTIVE = 2;
    localparam int M_STALL  = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       init  = 1'b0;
    logic [3:0] credits;
    logic       idle;
    logic       error;
`ifdef PCIE_TX_STATS_EN
    logic [31:0] cnt_class;
`endif

    pcie_tx_injector_if bus ();

    pcie_tx_injector dut (
        .clk     (clk),
        .reset   (reset),
        .init    (init),
        .bus     (bus),
        .credits (credits),
        .idle    (idle),
        .error   (error)
`ifdef PCIE_TX_STATS_EN
        ,
        .cnt_class (cnt_class)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          m_mode;
    int          m_credits;
    int          m_rr;
    logic        m_err;
    int          m_cnt [4];
    logic [1:0]  p_dest [4];
    logic [7:0]  p_data [4];
    logic [11:0] exp_q [$];
    logic [11:0] mon_word;
    logic        mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Class chosen by the round-robin rule, or -1 when nothing may be granted.
    function automatic int model_grant(input logic [3:0] v);
        if (m_mode != M_ACTIVE || m_credits == 0) return -1;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_rr + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One clock cycle of stimulus: drive, check the grant, advance the model.
    task automatic step(input logic [3:0] v, input logic cr, input logic in);
        int         g;
        int         nc;
        logic [3:0] exp_ready;
        bus.src_valid  = v;
        bus.credit_ret = cr;
        init           = in;
        for (int c = 0; c < 4; c++) begin
            bus.src_dest[2*c +: 2] = p_dest[c];
            bus.src_data[8*c +: 8] = p_data[c];
        end
        #1;
        g         = model_grant(v);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("src_ready", 32'(bus.src_ready), 32'(exp_ready));

        if (g >= 0) begin
            exp_q.push_back({2'(g), p_dest[g], p_data[g]});
            m_cnt[g]  = m_cnt[g] + 1;
            m_rr      = (g + 1) % 4;
            p_dest[g] = 2'($urandom_range(0, 3));
            p_data[g] = 8'($urandom_range(0, 255));
        end

        nc = m_credits;
        if (m_mode == M_INIT) begin
            nc = CREDITOS;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else if (g >= 0 && !cr) begin
            nc = m_credits - 1;
        end else if (g < 0 && cr) begin
            if (m_credits == CREDITOS) m_err = 1'b1;
            else nc = m_credits + 1;
        end

        case (m_mode)
            M_INIT:   m_mode = M_IDLE;
            M_IDLE:   m_mode = in ? M_INIT : (v != 0 ? M_ACTIVE : M_IDLE);
            M_ACTIVE: m_mode = (v == 0) ? M_IDLE : (nc == 0 ? M_STALL : M_ACTIVE);
            default:  m_mode = cr ? M_ACTIVE : M_STALL;
        endcase
        m_credits = nc;
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_mode    = M_INIT;
        m_credits = 0;
        m_rr      = 0;
        m_err     = 1'b0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
    endtask

    // Hold reset for two cycles, check the reset values, then release.
    task automatic do_reset();
        mon_en         = 1'b0;
        reset          = 1'b0;
        bus.src_valid  = '0;
        bus.credit_ret = 1'b0;
        init           = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_push", 32'(bus.push), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_credits", 32'(credits), 32'd0);
        check("rst_idle", 32'(idle), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_src_ready", 32'(bus.src_ready), 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: every push must match the oldest expected word, and no push may appear unexpected.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                mon_word = exp_q.pop_front();
                check("push", 32'(bus.push), 32'd1);
                check("data_out", 32'(bus.data_out), 32'(mon_word));
            end else begin
                check("no_push", 32'(bus.push), 32'd0);
            end
            check("credits", 32'(credits), 32'(m_credits));
            check("idle", 32'(idle), 32'(m_mode == M_IDLE));
            check("error", 32'(error), 32'(m_err));
`ifdef PCIE_TX_STATS_EN
            check("cnt_class", cnt_class,
                  {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])});
`endif
        end
    end

    int rot [5] = '{0, 1, 2, 3, 0};

    initial begin
        foreach (p_dest[i]) begin
            p_dest[i] = 2'($urandom_range(0, 3));
            p_data[i] = 8'($urandom_range(0, 255));
        end
        bus.src_valid  = '0;
        bus.src_dest   = '0;
        bus.src_data   = '0;
        bus.credit_ret = 1'b0;

        // Rotation, credit exhaustion, stall recovery, cancellation and overflow.
        do_reset();
        step(4'b0000, 1'b0, 1'b0);
        check("idle_after_init", 32'(idle), 32'd1);
        check("credits_after_init", 32'(credits), 32'd8);
        step(4'b1111, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1'b0, 1'b0);
            check("rotation_class", 32'(bus.data_out[11:10]), 32'(rot[k]));
        end
        repeat (3) step(4'b1111, 1'b0, 1'b0);
        check("stall_credits", 32'(credits), 32'd0);
        check("stall_ready", 32'(bus.src_ready), 32'd0);
        step(4'b1111, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        check("one_more_push", 32'(bus.push), 32'd1);
        repeat (2) step(4'b1111, 1'b0, 1'b0);
        repeat (4) step(4'b0000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        check("hs_and_ret_credits", 32'(credits), 32'd5);
        repeat (3) step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("overflow_error", 32'(error), 32'd1);
        check("overflow_credits", 32'(credits), 32'd8);

        // Single class-2 word, then init from IDLE.
        do_reset();
        step(4'b0000, 1'b0, 1'b0);
        p_dest[2] = 2'd3;
        p_data[2] = 8'hA5;
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        check("class2_push", 32'(bus.push), 32'd1);
        check("class2_word", 32'(bus.data_out), 32'hBA5);
        check("class2_credits", 32'(credits), 32'd7);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        check("reinit_credits", 32'(credits), 32'd8);

        // Randomized traffic, returns and init pulses.
        do_reset();
        step(4'b0000, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            step(4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset while a push is on the output.
        do_reset();
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        check("pre_reset_push", 32'(bus.push), 32'd1);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("async_push", 32'(bus.push), 32'd0);
        check("async_data_out", 32'(bus.data_out), 32'd0);
        check("async_credits", 32'(credits), 32'd0);
        check("async_idle", 32'(idle), 32'd0);
        @(negedge clk);
        do_reset();
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

`ifdef PCIE_TX_STATS_EN
        // Three class-1 and two class-3 handshakes, then init clears the counters.
        do_reset();
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        repeat (3) step(4'b0010, 1'b0, 1'b0);
        repeat (2) step(4'b1000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check("stats_counts", cnt_class, 32'h02000300);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        check("stats_cleared", cnt_class, 32'h00000000);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
